// File: rtl/bram_pkg.sv
// Shared definitions for the multiport block RAM: read-during-write modes,
// clear-engine state encoding and the byte-lane merge helper.
package bram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // Widest word the merge helper handles; callers cast in and out of this width.
   localparam int MERGE_MAXW = 256;
   localparam int MASKW      = MERGE_MAXW / 8;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_t;

   function automatic logic [MERGE_MAXW-1:0] merge_bytes(
      input logic [MERGE_MAXW-1:0] old_word,
      input logic [MERGE_MAXW-1:0] new_word,
      input logic [MASKW-1:0]      mask
   );
      logic [MERGE_MAXW-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MASKW; b++) begin
         if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/bram_read_port.sv
// One synchronous read port: stage-1 capture with optional write-first bypass,
// optional stage-2 output register, and matching valid shift bits.
module bram_read_port
   import bram_pkg::*;
#(
   parameter int DW       = 32,
   parameter int OUTREG   = 0,
   parameter int RDW_MODE = 0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            i_accept,
   input  logic [DW-1:0]   i_mem_word,
   input  logic            i_wr_hit,
   input  logic [DW-1:0]   i_wr_data,
   input  logic [DW/8-1:0] i_wr_mask,
   output logic [DW-1:0]   o_data,
   output logic            o_valid
);

   logic [DW-1:0] w_merged;
   logic [DW-1:0] w_capture;
   logic [DW-1:0] r_s1;
   logic          r_v1;

   assign w_merged  = DW'(merge_bytes(MERGE_MAXW'(i_mem_word), MERGE_MAXW'(i_wr_data),
                                      MASKW'(i_wr_mask)));
   assign w_capture = (RDW_MODE == RDW_WRITE_FIRST && i_wr_hit) ? w_merged : i_mem_word;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_s1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= i_accept;
         if (i_accept) r_s1 <= w_capture;
      end
   end

   generate
      if (OUTREG != 0) begin : g_out2
         logic [DW-1:0] r_s2;
         logic          r_v2;
         always_ff @(posedge CLK) begin
            if (!RST) begin
               r_s2 <= '0;
               r_v2 <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_s2 <= r_s1;
            end
         end
         assign o_data  = r_s2;
         assign o_valid = r_v2;
      end else begin : g_out1
         assign o_data  = r_s1;
         assign o_valid = r_v1;
      end
   endgenerate

endmodule

// File: rtl/multiport_bram.sv
// Byte-enabled single-write / NRP-read block RAM with a post-reset clear engine
// that zeroes the array before any request is served.
//
//   state | meaning
//   IDLE  | serving reads and writes
//   CLEAR | zeroing ram[clear_ptr] each cycle, requests ignored (busy)
module multiport_bram
   import bram_pkg::*;
#(
   parameter int datawidth      = 32,
   parameter int addrwidth      = 8,
   parameter int NRP            = 2,
   parameter int OUTREG         = 0,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NRP*addrwidth-1:0] read_addr,
   input  logic [NRP-1:0]           read_addr_valid,
   output logic [NRP*datawidth-1:0] read_data,
   output logic [NRP-1:0]           read_data_valid,
   input  logic                     write_enable,
   input  logic [datawidth/8-1:0]   write_byte_en,
   input  logic [addrwidth-1:0]     write_addr,
   input  logic [datawidth-1:0]     write_data,
   output logic                     busy
);

   localparam int DEPTH = 1 << addrwidth;
   localparam int NB    = datawidth / 8;
   localparam logic [addrwidth-1:0] LAST_ADDR = '1;

   generate
      if (datawidth % 8 != 0 || datawidth > MERGE_MAXW) begin : g_bad_dw
         $error("multiport_bram: datawidth must be a multiple of 8 and at most %0d", MERGE_MAXW);
      end
      if (NRP < 1 || NRP > 4) begin : g_bad_nrp
         $error("multiport_bram: NRP must be within 1..4");
      end
   endgenerate

   logic [datawidth-1:0] r_mem [DEPTH];

   clr_state_t           r_state;
   clr_state_t           w_state_nxt;
   logic [addrwidth-1:0] r_clear_ptr;
   logic [addrwidth-1:0] w_clear_ptr_nxt;
   logic                 w_wr_acc;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         r_clear_ptr <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clear_ptr <= w_clear_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_clear_ptr_nxt = r_clear_ptr;
      if (r_state == CLEAR) begin
         w_clear_ptr_nxt = r_clear_ptr + 1'b1;
         if (r_clear_ptr == LAST_ADDR) w_state_nxt = IDLE;
      end
   end

   assign busy     = (r_state == CLEAR);
   assign w_wr_acc = RST && !busy && write_enable;

   // The array is deliberately left untouched while RST is low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         if (r_state == CLEAR) begin
            r_mem[r_clear_ptr] <= '0;
         end else if (w_wr_acc) begin
            for (int b = 0; b < NB; b++) begin
               if (write_byte_en[b]) r_mem[write_addr][8*b +: 8] <= write_data[8*b +: 8];
            end
         end
      end
   end

   generate
      for (genvar p = 0; p < NRP; p++) begin : g_port
         logic [addrwidth-1:0] w_addr;
         logic [datawidth-1:0] w_word;
         logic                 w_accept;
         logic                 w_hit;

         assign w_addr   = read_addr[p*addrwidth +: addrwidth];
         assign w_word   = r_mem[w_addr];
         assign w_accept = RST && !busy && read_addr_valid[p];
         assign w_hit    = w_wr_acc && (w_addr == write_addr);

         bram_read_port #(
            .DW       (datawidth),
            .OUTREG   (OUTREG),
            .RDW_MODE (RDW_MODE)
         ) u_rd (
            .CLK        (CLK),
            .RST        (RST),
            .i_accept   (w_accept),
            .i_mem_word (w_word),
            .i_wr_hit   (w_hit),
            .i_wr_data  (write_data),
            .i_wr_mask  (write_byte_en),
            .o_data     (read_data[p*datawidth +: datawidth]),
            .o_valid    (read_data_valid[p])
         );
      end
   endgenerate

endmodule

// File: tb/tb_multiport_bram.sv
// Directed bench: two instances share stimulus; dut_a is OUTREG=0/read-first,
// dut_b is OUTREG=1/write-first, both 16 words deep.
module tb_multiport_bram;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int NRP = 2;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic [NRP*AW-1:0] read_addr = '0;
   logic [NRP-1:0]    read_addr_valid = '0;
   logic              write_enable = 1'b0;
   logic [DW/8-1:0]   write_byte_en = '0;
   logic [AW-1:0]     write_addr = '0;
   logic [DW-1:0]     write_data = '0;

   logic [NRP*DW-1:0] rd_a, rd_b;
   logic [NRP-1:0]    rv_a, rv_b;
   logic              busy_a, busy_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   multiport_bram #(.datawidth(DW), .addrwidth(AW), .NRP(NRP), .OUTREG(0),
                    .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
      .CLK(CLK), .RST(RST), .read_addr(read_addr), .read_addr_valid(read_addr_valid),
      .read_data(rd_a), .read_data_valid(rv_a), .write_enable(write_enable),
      .write_byte_en(write_byte_en), .write_addr(write_addr), .write_data(write_data),
      .busy(busy_a));

   multiport_bram #(.datawidth(DW), .addrwidth(AW), .NRP(NRP), .OUTREG(1),
                    .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
      .CLK(CLK), .RST(RST), .read_addr(read_addr), .read_addr_valid(read_addr_valid),
      .read_data(rd_b), .read_data_valid(rv_b), .write_enable(write_enable),
      .write_byte_en(write_byte_en), .write_addr(write_addr), .write_data(write_data),
      .busy(busy_b));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] m);
      write_enable  = 1'b1;
      write_addr    = a;
      write_data    = d;
      write_byte_en = m;
      tick();
      write_enable  = 1'b0;
      write_byte_en = '0;
   endtask

   task automatic test_reset();
      int n;
      RST = 1'b0;
      tick();
      tick();
      vectors++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_busy got %b/%b want 1/1", busy_a, busy_b);
      end
      vectors++;
      if (rv_a !== 2'b00 || rv_b !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_valid got %b/%b want 00/00", rv_a, rv_b);
      end
      vectors++;
      if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h/%h want 0/0", rd_a, rd_b);
      end
      RST = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy_a && n < 40);
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL clear_cycles got %0d want 16", n);
      end
      vectors++;
      if (busy_b !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_busy_b got %b want 0", busy_b);
      end
   endtask

   task automatic test_clear_contents();
      for (int a = 0; a < 16; a++) begin
         read_addr       = {4'(15 - a), 4'(a)};
         read_addr_valid = 2'b11;
         tick();
         read_addr_valid = 2'b00;
         vectors++;
         if (rv_a !== 2'b11 || rd_a !== 64'h0) begin
            miscompares++;
            $display("FAIL clear_read_a addr %0d got %b %h want 11 0", a, rv_a, rd_a);
         end
         tick();
         vectors++;
         if (rv_b !== 2'b11 || rd_b !== 64'h0) begin
            miscompares++;
            $display("FAIL clear_read_b addr %0d got %b %h want 11 0", a, rv_b, rd_b);
         end
      end
   endtask

   task automatic test_byte_enables();
      write_word(4'd3, 32'hAABBCCDD, 4'b1111);
      write_word(4'd3, 32'h11223344, 4'b0101);
      read_addr       = {4'd3, 4'd3};
      read_addr_valid = 2'b11;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rv_a !== 2'b11 || rd_a !== 64'hAA22CC44_AA22CC44) begin
         miscompares++;
         $display("FAIL bytes_a got %b %h want 11 aa22cc44aa22cc44", rv_a, rd_a);
      end
      tick();
      vectors++;
      if (rv_b !== 2'b11 || rd_b !== 64'hAA22CC44_AA22CC44) begin
         miscompares++;
         $display("FAIL bytes_b got %b %h want 11 aa22cc44aa22cc44", rv_b, rd_b);
      end
      write_word(4'd7, 32'h55667788, 4'b0000);
      read_addr       = {4'd7, 4'd7};
      read_addr_valid = 2'b01;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rd_a[31:0] !== 32'h0) begin
         miscompares++;
         $display("FAIL zero_mask got %h want 00000000", rd_a[31:0]);
      end
      tick();
   endtask

   task automatic test_latency();
      read_addr       = {4'd0, 4'd3};
      read_addr_valid = 2'b01;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rv_a !== 2'b01 || rd_a[31:0] !== 32'hAA22CC44) begin
         miscompares++;
         $display("FAIL lat_a_t1 got %b %h want 01 aa22cc44", rv_a, rd_a[31:0]);
      end
      vectors++;
      if (rv_b !== 2'b00) begin
         miscompares++;
         $display("FAIL lat_b_t1 got %b want 00", rv_b);
      end
      tick();
      vectors++;
      if (rv_a !== 2'b00 || rd_a !== 64'hAA22CC44_AA22CC44) begin
         miscompares++;
         $display("FAIL lat_a_hold got %b %h want 00 aa22cc44aa22cc44", rv_a, rd_a);
      end
      vectors++;
      if (rv_b !== 2'b01 || rd_b[31:0] !== 32'hAA22CC44) begin
         miscompares++;
         $display("FAIL lat_b_t2 got %b %h want 01 aa22cc44", rv_b, rd_b[31:0]);
      end
      tick();
      vectors++;
      if (rv_b !== 2'b00 || rd_b !== 64'hAA22CC44_AA22CC44) begin
         miscompares++;
         $display("FAIL lat_b_hold got %b %h want 00 aa22cc44aa22cc44", rv_b, rd_b);
      end
   endtask

   task automatic test_rdw();
      read_addr       = {4'd0, 4'd5};
      read_addr_valid = 2'b01;
      write_word(4'd5, 32'hFFFFFFFF, 4'b0011);
      read_addr_valid = 2'b00;
      vectors++;
      if (rv_a !== 2'b01 || rd_a[31:0] !== 32'h00000000) begin
         miscompares++;
         $display("FAIL rdw_read_first got %b %h want 01 00000000", rv_a, rd_a[31:0]);
      end
      tick();
      vectors++;
      if (rv_b !== 2'b01 || rd_b[31:0] !== 32'h0000FFFF) begin
         miscompares++;
         $display("FAIL rdw_write_first got %b %h want 01 0000ffff", rv_b, rd_b[31:0]);
      end
      read_addr_valid = 2'b01;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rd_a[31:0] !== 32'h0000FFFF) begin
         miscompares++;
         $display("FAIL rdw_after got %h want 0000ffff", rd_a[31:0]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] req_p0 [3];
      logic [31:0] req_p1 [3];
      req_p0 = '{32'hAA22CC44, 32'h0000FFFF, 32'hAA22CC44};
      req_p1 = '{32'h0000FFFF, 32'hAA22CC44, 32'h0000FFFF};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            read_addr       = (i == 1) ? {4'd3, 4'd5} : {4'd5, 4'd3};
            read_addr_valid = 2'b11;
         end else begin
            read_addr_valid = 2'b00;
         end
         tick();
         vectors++;
         if (i < 3) begin
            if (rv_a !== 2'b11 || rd_a !== {req_p1[i], req_p0[i]}) begin
               miscompares++;
               $display("FAIL b2b_a step %0d got %b %h want 11 %h", i, rv_a, rd_a,
                        {req_p1[i], req_p0[i]});
            end
         end else if (rv_a !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_a_end got %b want 00", rv_a);
         end
         vectors++;
         if (i >= 1) begin
            if (rv_b !== 2'b11 || rd_b !== {req_p1[i-1], req_p0[i-1]}) begin
               miscompares++;
               $display("FAIL b2b_b step %0d got %b %h want 11 %h", i, rv_b, rd_b,
                        {req_p1[i-1], req_p0[i-1]});
            end
         end else if (rv_b !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_b_start got %b want 00", rv_b);
         end
      end
      tick();
   endtask

   task automatic test_busy_gating();
      int n;
      RST = 1'b0;
      tick();
      RST             = 1'b1;
      write_enable    = 1'b1;
      write_addr      = 4'd2;
      write_data      = 32'h12345678;
      write_byte_en   = 4'b1111;
      read_addr       = {4'd2, 4'd2};
      read_addr_valid = 2'b11;
      n = 0;
      do begin
         tick();
         n++;
         vectors++;
         if (rv_a !== 2'b00 || rv_b !== 2'b00) begin
            miscompares++;
            $display("FAIL busy_valid cycle %0d got %b/%b want 00/00", n, rv_a, rv_b);
         end
      end while (busy_a && n < 40);
      write_enable    = 1'b0;
      write_byte_en   = '0;
      read_addr_valid = 2'b00;
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL busy_cycles got %0d want 16", n);
      end
      read_addr       = {4'd3, 4'd2};
      read_addr_valid = 2'b11;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rv_a !== 2'b11 || rd_a !== 64'h0) begin
         miscompares++;
         $display("FAIL busy_write_ignored got %b %h want 11 0", rv_a, rd_a);
      end
      tick();
   endtask

   task automatic test_reset_mid_clear();
      int n;
      write_word(4'd9, 32'hDEADBEEF, 4'b1111);
      write_word(4'd15, 32'hCAFEF00D, 4'b1111);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      RST = 1'b0;
      tick();
      vectors++;
      if (busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_busy got %b want 1", busy_a);
      end
      RST = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy_a && n < 40);
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL mid_clear_cycles got %0d want 16", n);
      end
      read_addr       = {4'd15, 4'd9};
      read_addr_valid = 2'b11;
      tick();
      read_addr_valid = 2'b00;
      vectors++;
      if (rv_a !== 2'b11 || rd_a !== 64'h0) begin
         miscompares++;
         $display("FAIL mid_clear_zero got %b %h want 11 0", rv_a, rd_a);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_clear_contents();
      test_byte_enables();
      test_latency();
      test_rdw();
      test_back_to_back();
      test_busy_gating();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
